// File: rtl/rtm_pkg.sv
// Shared types for the register-transfer machine: opcodes, sequencer states
// and the address-width helper.
package rtm_pkg;

    typedef enum logic [2:0] {
        OP_LOAD   = 3'd0,
        OP_ADD    = 3'd1,
        OP_SUB    = 3'd2,
        OP_MOV    = 3'd3,
        OP_CLRALL = 3'd4,
        OP_MUL    = 3'd5,
        OP_RSV    = 3'd6,
        OP_RSV7   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_CLR  = 2'd3
    } state_t;

    // Smallest r with 2**r >= n (0 for n <= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/rtm_seq_datapath_if.sv
// Command handshake plus observable buses and flags of the sequenced datapath.
interface rtm_seq_datapath_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AW-1:0]    cmd_dst;
    logic [AW-1:0]    cmd_sa;
    logic [AW-1:0]    cmd_sb;
    logic [WIDTH-1:0] cmd_data;
    logic             carry_in;
    logic             done;
    logic             cmd_err;
    logic             carry_out;
    logic             zero;
    logic [WIDTH-1:0] a_bus;
    logic [WIDTH-1:0] b_bus;
    logic [WIDTH-1:0] d_bus;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_sa, cmd_sb, cmd_data, carry_in,
        input  cmd_ready, done, cmd_err, carry_out, zero, a_bus, b_bus, d_bus
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_sa, cmd_sb, cmd_data, carry_in,
        output cmd_ready, done, cmd_err, carry_out, zero, a_bus, b_bus, d_bus
    );
endinterface

// File: rtl/rtm_regfile.sv
// NREGS x WIDTH register file: one synchronous write port, two asynchronous
// read ports, whole-array synchronous clear.
module rtm_regfile
    import rtm_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    parameter int AW    = clog2(NREGS)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);
    logic [NREGS-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clock) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!clear_n)
                mem[i] <= '0;
            else if (we && (waddr == AW'(i)))
                mem[i] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/rtm_seq_datapath.sv
// Command-driven register-transfer machine: single-cycle ALU ops, a WIDTH-cycle
// shift-add multiply and an NREGS-cycle clear sweep, with registered flags.
module rtm_seq_datapath
    import rtm_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREGS = 4
) (
    input  logic                clock,
    input  logic                clear_n,
    rtm_seq_datapath_if.slave   bus
);
    localparam int AW = clog2(NREGS);
    localparam int CW = clog2((WIDTH > NREGS) ? WIDTH : NREGS) + 1;

    state_t             state, state_n;
    op_t                op_q;
    logic [AW-1:0]      dst_q;
    logic               cin_q;
    logic [WIDTH-1:0]   data_q, opa_q, opb_q;
    logic [2*WIDTH-1:0] acc, acc_nxt, pp;
    logic [WIDTH-1:0]   opb_sh;
    logic [CW-1:0]      cnt;
    logic               carry_q, zero_q, done_q, err_q;

    logic               accept;
    logic               we;
    logic [AW-1:0]      waddr;
    logic [WIDTH-1:0]   wdata;
    logic               upd_c, upd_z, c_n, z_n, fin, err_c;
    logic [WIDTH:0]     add_r, sub_r;
    logic               mul_last, clr_last;

    rtm_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_rf (
        .clock   (clock),
        .clear_n (clear_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (bus.cmd_sa),
        .raddr_b (bus.cmd_sb),
        .rdata_a (bus.a_bus),
        .rdata_b (bus.b_bus)
    );

    assign bus.cmd_ready = (state == ST_IDLE) && clear_n;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    assign add_r = {1'b0, opa_q} + {1'b0, opb_q} + {{WIDTH{1'b0}}, cin_q};
    assign sub_r = {1'b0, opa_q} + {1'b0, ~opb_q} + {{WIDTH{1'b0}}, 1'b1};

    // Multiply step cnt adds opa<<cnt when opb bit cnt is set.
    assign opb_sh   = opb_q >> cnt;
    assign pp       = opb_sh[0] ? ({{WIDTH{1'b0}}, opa_q} << cnt) : '0;
    assign acc_nxt  = acc + pp;
    assign mul_last = (cnt == CW'(WIDTH - 1));
    assign clr_last = (cnt == CW'(NREGS - 1));

    always_comb begin
        state_n = state;
        we      = 1'b0;
        waddr   = dst_q;
        wdata   = '0;
        upd_c   = 1'b0;
        upd_z   = 1'b0;
        c_n     = carry_q;
        z_n     = zero_q;
        fin     = 1'b0;
        err_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op_t'(bus.cmd_op))
                        OP_MUL:    state_n = ST_MUL;
                        OP_CLRALL: state_n = ST_CLR;
                        default:   state_n = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                state_n = ST_IDLE;
                fin     = 1'b1;
                case (op_q)
                    OP_LOAD: begin we = 1'b1; wdata = data_q; upd_z = 1'b1; end
                    OP_MOV:  begin we = 1'b1; wdata = opa_q;  upd_z = 1'b1; end
                    OP_ADD: begin
                        we = 1'b1; wdata = add_r[WIDTH-1:0];
                        upd_c = 1'b1; upd_z = 1'b1; c_n = add_r[WIDTH];
                    end
                    OP_SUB: begin
                        we = 1'b1; wdata = sub_r[WIDTH-1:0];
                        upd_c = 1'b1; upd_z = 1'b1; c_n = sub_r[WIDTH];
                    end
                    default: err_c = 1'b1;
                endcase
            end
            ST_MUL: begin
                if (mul_last) begin
                    state_n = ST_IDLE;
                    fin     = 1'b1;
                    we      = 1'b1;
                    wdata   = acc_nxt[WIDTH-1:0];
                    upd_c   = 1'b1;
                    upd_z   = 1'b1;
                    c_n     = |acc_nxt[2*WIDTH-1:WIDTH];
                end
            end
            ST_CLR: begin
                we    = 1'b1;
                waddr = cnt[AW-1:0];
                if (clr_last) begin
                    state_n = ST_IDLE;
                    fin     = 1'b1;
                    upd_c   = 1'b1;
                    upd_z   = 1'b1;
                    c_n     = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (upd_z) z_n = (wdata == '0);
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state   <= ST_IDLE;
            op_q    <= OP_LOAD;
            dst_q   <= '0;
            cin_q   <= 1'b0;
            data_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc     <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= fin;
            err_q  <= err_c;
            if (upd_c) carry_q <= c_n;
            if (upd_z) zero_q  <= z_n;
            if (accept) begin
                op_q   <= op_t'(bus.cmd_op);
                dst_q  <= bus.cmd_dst;
                cin_q  <= bus.carry_in;
                data_q <= bus.cmd_data;
                opa_q  <= bus.a_bus;
                opb_q  <= bus.b_bus;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == ST_MUL) begin
                acc <= acc_nxt;
                cnt <= cnt + CW'(1);
            end else if (state == ST_CLR) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.done      = done_q;
    assign bus.cmd_err   = err_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;
    assign bus.d_bus     = we ? wdata : '0;
endmodule

// File: tb/tb_rtm_seq_datapath.sv
// Directed and random commands against an arithmetic reference model of the
// register file and flags.
module tb_rtm_seq_datapath;
    localparam int W = 4;
    localparam int N = 4;
    localparam int M = 1 << W;

    logic clock = 1'b0;
    logic clear_n;
    always #5 clock = ~clock;

    rtm_seq_datapath_if #(.WIDTH(W), .AW(2)) bus ();
    rtm_seq_datapath #(.WIDTH(W), .NREGS(N)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int mreg[N];
    int mc, mz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < N; i++) begin
            @(negedge clock);
            bus.cmd_sa = 2'(i);
            bus.cmd_sb = 2'(N - 1 - i);
            #1;
            chk({tag, "_a"}, 32'(bus.a_bus), 32'(mreg[i]));
            chk({tag, "_b"}, 32'(bus.b_bus), 32'(mreg[N-1-i]));
        end
        chk({tag, "_carry"}, 32'(bus.carry_out), 32'(mc));
        chk({tag, "_zero"},  32'(bus.zero),      32'(mz));
    endtask

    // Issue one command, then walk cycle by cycle to the expected done pulse.
    task automatic run_cmd(input int op, input int dst, input int sa, input int sb,
                           input int data, input int cin, input bit hold, input string tag);
        int a, b, s, res, lat, g;
        bit wr, rsv, updc;
        int newc;
        a = mreg[sa]; b = mreg[sb];
        wr = 1; rsv = 0; updc = 0; res = 0; newc = mc;
        lat = 2;
        case (op)
            0: res = data;
            1: begin s = a + b + cin;           res = s % M; newc = s / M; updc = 1; end
            2: begin s = a + (M - 1 - b) + 1;   res = s % M; newc = s / M; updc = 1; end
            3: res = a;
            4: begin wr = 0; lat = N + 1; end
            5: begin s = a * b; res = s % M; newc = (s >= M) ? 1 : 0; updc = 1; lat = W + 1; end
            default: begin wr = 0; rsv = 1; end
        endcase

        @(negedge clock);
        g = 0;
        while (!bus.cmd_ready && g < 20) begin
            @(negedge clock);
            g++;
        end
        chk({tag, "_ready_in"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_op    = 3'(op);
        bus.cmd_dst   = 2'(dst);
        bus.cmd_sa    = 2'(sa);
        bus.cmd_sb    = 2'(sb);
        bus.cmd_data  = 4'(data);
        bus.carry_in  = cin[0];
        bus.cmd_valid = 1'b1;
        @(posedge clock);

        if (op == 4) begin
            for (int i = 0; i < N; i++) mreg[i] = 0;
            newc = 0;
        end else if (wr) begin
            mreg[dst] = res;
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            chk({tag, "_done"},  32'(bus.done),      32'(k == lat));
            chk({tag, "_err"},   32'(bus.cmd_err),   32'(rsv && k == lat));
            chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'(k == lat));
            if (wr && k == lat - 1)
                chk({tag, "_dbus"}, 32'(bus.d_bus), 32'(res));
            if (op == 4 && k >= 2) begin
                bus.cmd_sa = 2'(k - 2);
                #1;
                chk({tag, "_sweep"}, 32'(bus.a_bus), 32'd0);
            end
            if (k == lat) begin
                if (op == 4) mz = 1;
                else if (wr) mz = (res == 0) ? 1 : 0;
                if (updc || op == 4) mc = newc;
                chk({tag, "_cflag"}, 32'(bus.carry_out), 32'(mc));
                chk({tag, "_zflag"}, 32'(bus.zero),      32'(mz));
            end
            if (!hold || k == lat) bus.cmd_valid = 1'b0;
        end
    endtask

    initial begin
        clear_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_dst   = '0;
        bus.cmd_sa    = '0;
        bus.cmd_sb    = '0;
        bus.cmd_data  = '0;
        bus.carry_in  = 1'b0;
        for (int i = 0; i < N; i++) mreg[i] = 0;
        mc = 0; mz = 0;

        repeat (2) begin
            @(negedge clock);
            chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        end
        clear_n = 1'b1;
        @(negedge clock);
        chk("rst_ready_rel", 32'(bus.cmd_ready), 32'd1);
        chk("rst_done",      32'(bus.done),      32'd0);
        check_state("rst");

        run_cmd(0, 1, 0, 0, 5,   0, 0, "ld_r1");
        run_cmd(0, 2, 0, 0, 11,  0, 0, "ld_r2");
        run_cmd(1, 3, 1, 2, 0,   0, 0, "add");
        check_state("add_st");
        run_cmd(2, 0, 2, 1, 0,   0, 0, "sub1");
        run_cmd(2, 0, 1, 2, 0,   0, 0, "sub2");
        check_state("sub_st");
        run_cmd(0, 0, 0, 0, 3,   0, 0, "ld_r0");
        run_cmd(5, 3, 1, 0, 0,   0, 0, "mul1");
        run_cmd(5, 3, 1, 2, 0,   0, 0, "mul2");
        check_state("mul_st");
        run_cmd(4, 0, 0, 0, 0,   0, 1, "clr");
        check_state("clr_st");
        run_cmd(0, 2, 0, 0, 9,   0, 0, "ld_r2b");
        run_cmd(6, 2, 2, 2, 0,   0, 0, "rsv6");
        check_state("rsv_st");

        // Reset arriving two cycles into a multiply abandons it.
        run_cmd(0, 1, 0, 0, 7, 0, 0, "ld_pre");
        @(negedge clock);
        bus.cmd_op = 3'd5; bus.cmd_dst = 2'd3; bus.cmd_sa = 2'd1; bus.cmd_sb = 2'd1;
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        @(negedge clock);
        clear_n = 1'b0;
        for (int i = 0; i < N; i++) mreg[i] = 0;
        mc = 0; mz = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("midrst_done",  32'(bus.done),      32'd0);
            chk("midrst_ready", 32'(bus.cmd_ready), 32'd0);
        end
        clear_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("midrst_nodone", 32'(bus.done),      32'd0);
            chk("midrst_idle",   32'(bus.cmd_ready), 32'd1);
        end
        check_state("midrst_st");

        for (int n = 0; n < 40; n++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, N - 1)),
                    int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
                    int'($urandom_range(0, M - 1)), int'($urandom_range(0, 1)), 0, "rnd");
            check_state("rnd_st");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
